// File: rtl/dbus_mem_responder.sv
// Data-bus memory responder: single-port 64-bit memory, fixed latency, byte strobes.
// Optional alignment checking with DBUS_MISALIGN_CHECK_EN (adds the misalign port).
package dbus_pkg;
   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

module dbus_mem_responder
   import dbus_pkg::*;
#(
   parameter int MEM_WORDS = 4096,
   parameter int LATENCY   = 2,
   parameter int INIT_ZERO = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
`ifdef DBUS_MISALIGN_CHECK_EN
   output logic       misalign,
`endif
   output dbus_resp_t dresp
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   a_idx;
   logic [7:0]      a_strb;
   logic [63:0]     a_data;
   logic [63:0]     merged;
   logic [AW-1:0]   rd_idx;
   logic            enter_resp;
   logic            commit;
   logic            unused_bits;

   logic [63:0] mem [MEM_WORDS] =
      '{default: (INIT_ZERO != 0) ? 64'd0 : 64'bx};

   assign unused_bits = ^{dreq.addr[63:AW+3], dreq.addr[2:0], dreq.size};

`ifdef DBUS_MISALIGN_CHECK_EN
   logic [2:0] a_lo;
   msize_t     a_size;
   logic       req_mis;

   function automatic logic is_mis(logic [2:0] lo, msize_t sz);
      logic m;
      m = 1'b0;
      case (sz)
         MSIZE2:  m = lo[0] != 1'b0;
         MSIZE4:  m = lo[1:0] != 2'b00;
         MSIZE8:  m = lo != 3'b000;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   assign req_mis = (state == IDLE) ? is_mis(dreq.addr[2:0], dreq.size)
                                    : is_mis(a_lo, a_size);
   assign commit  = (state == RESP) && (a_strb != 8'h00) && !reset &&
                    !is_mis(a_lo, a_size);
`else
   assign commit  = (state == RESP) && (a_strb != 8'h00) && !reset;
`endif

   // Entering RESP either straight from IDLE (LATENCY==1) or at the end of WAIT
   assign enter_resp = ((state == IDLE) && dreq.valid && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == CW'(1)));
   assign rd_idx     = (state == IDLE) ? dreq.addr[3 +: AW] : a_idx;

   always_comb begin
      merged = mem[a_idx];
      for (int i = 0; i < 8; i++) begin
         if (a_strb[i]) merged[8*i +: 8] = a_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         dresp.addr_ok <= 1'b0;
         dresp.data_ok <= 1'b0;
         dresp.data    <= '0;
`ifdef DBUS_MISALIGN_CHECK_EN
         misalign      <= 1'b0;
`endif
      end else begin
         dresp.addr_ok <= 1'b0;
         dresp.data_ok <= 1'b0;
`ifdef DBUS_MISALIGN_CHECK_EN
         misalign      <= 1'b0;
`endif
         if (enter_resp) begin
            dresp.addr_ok <= 1'b1;
            dresp.data_ok <= 1'b1;
            dresp.data    <= mem[rd_idx];
`ifdef DBUS_MISALIGN_CHECK_EN
            misalign      <= req_mis;
`endif
         end
         unique case (state)
            IDLE: begin
               if (dreq.valid) begin
                  a_idx  <= dreq.addr[3 +: AW];
                  a_strb <= dreq.strobe;
                  a_data <= dreq.data;
`ifdef DBUS_MISALIGN_CHECK_EN
                  a_lo   <= dreq.addr[2:0];
                  a_size <= dreq.size;
`endif
                  cnt    <= CW'(LATENCY - 1);
                  state  <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= RESP;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Write lands on the RESP-exit edge, after the pre-write word was captured
   always_ff @(posedge clk) begin
      if (commit) mem[a_idx] <= merged;
   end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Scoreboard bench for dbus_mem_responder: directed requests, monitor checks each pulse.
// Misalignment cases run only when DBUS_MISALIGN_CHECK_EN is defined.
module tb_dbus_mem_responder;
   import dbus_pkg::*;

   localparam int LAT = 2;

   typedef struct {
      logic [63:0] data;
      int          cyc;
      bit          mis;
      string       name;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   dbus_req_t  dreq;
   dbus_resp_t dresp;
`ifdef DBUS_MISALIGN_CHECK_EN
   logic       misalign;
`endif

   exp_t q[$];
   int   cyc = 0;
   int   pulses = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   dbus_mem_responder #(
      .MEM_WORDS(4096),
      .LATENCY(LAT),
      .INIT_ZERO(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .dreq(dreq),
`ifdef DBUS_MISALIGN_CHECK_EN
      .misalign(misalign),
`endif
      .dresp(dresp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Monitor: pops one expectation per data_ok pulse
   always @(negedge clk) begin
      if (!reset && dresp.data_ok) begin
         exp_t e;
         pulses++;
         if (q.size() == 0) begin
            check("spurious_pulse", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            check({e.name, "_data"}, dresp.data, e.data);
            check({e.name, "_addr_ok"}, 64'(dresp.addr_ok), 64'd1);
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
`ifdef DBUS_MISALIGN_CHECK_EN
            check({e.name, "_misalign"}, 64'(misalign), 64'(e.mis));
`endif
         end
      end
   end

   task automatic txn(input string name, input logic [63:0] addr,
                      input msize_t sz, input logic [7:0] strb,
                      input logic [63:0] data, input logic [63:0] want,
                      input bit mis);
      exp_t e;
      int   p0;
      bit   seen;
      p0 = pulses;
      @(posedge clk);
      #1;
      dreq.valid  = 1'b1;
      dreq.addr   = addr;
      dreq.size   = sz;
      dreq.strobe = strb;
      dreq.data   = data;
      e.data = want;
      e.cyc  = cyc + LAT;
      e.mis  = mis;
      e.name = name;
      q.push_back(e);
      @(posedge clk);
      #1;
      // Scramble the bus: the latched request must be used
      dreq.valid  = 1'b0;
      dreq.addr   = 64'hFFFF_FFFF_FFFF_FFF8;
      dreq.strobe = 8'hFF;
      dreq.data   = 64'hBAD0_BAD0_BAD0_BAD0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #6;
         if (pulses != p0) seen = 1'b1;
      end
      if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      dreq = '0;
      dreq.size = MSIZE8;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
      check("rst_data_ok", 64'(dresp.data_ok), 64'd0);
      check("rst_data", dresp.data, 64'd0);

      txn("rd0", 64'h0, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b0);
      txn("wr10", 64'h10, MSIZE8, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0);
      txn("rd10", 64'h10, MSIZE8, 8'h00, 64'h0, 64'h1122334455667788, 1'b0);
      txn("wr10p", 64'h10, MSIZE8, 8'h0F, 64'hAAAAAAAABBBBBBBB,
          64'h1122334455667788, 1'b0);
      txn("rd10p", 64'h10, MSIZE8, 8'h00, 64'h0, 64'h11223344BBBBBBBB, 1'b0);
      txn("wr8000", 64'h8000, MSIZE8, 8'hFF, 64'hDEAD, 64'h0, 1'b0);
      txn("rdwrap", 64'h0, MSIZE8, 8'h00, 64'h0, 64'hDEAD, 1'b0);
      txn("wr20", 64'h20, MSIZE8, 8'hFF, 64'h77, 64'h0, 1'b0);
      txn("rd20", 64'h20, MSIZE8, 8'h00, 64'h0, 64'h77, 1'b0);
      txn("wrlanes", 64'h1D, MSIZE1, 8'h81, 64'hA1B2C3D4E5F60718,
          64'h0, 1'b0);
      txn("rdlanes", 64'h18, MSIZE8, 8'h00, 64'h0, 64'hA100000000000018, 1'b0);

      // Reset during WAIT of a write: no pulse, memory untouched
      p0 = pulses;
      @(posedge clk);
      #1;
      dreq.valid  = 1'b1;
      dreq.addr   = 64'h20;
      dreq.size   = MSIZE8;
      dreq.strobe = 8'hFF;
      dreq.data   = 64'h55;
      @(posedge clk);
      #1;
      dreq.valid = 1'b0;
      reset      = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #6;
      check("rstmid_no_pulse", 64'(pulses), 64'(p0));
      check("rstmid_data_ok", 64'(dresp.data_ok), 64'd0);
      check("rstmid_data", dresp.data, 64'd0);
      txn("rd20_after_rst", 64'h20, MSIZE8, 8'h00, 64'h0, 64'h77, 1'b0);

`ifdef DBUS_MISALIGN_CHECK_EN
      txn("wr22_mis", 64'h22, MSIZE4, 8'hFF, 64'h99, 64'h77, 1'b1);
      txn("rd20_mis", 64'h20, MSIZE8, 8'h00, 64'h0, 64'h77, 1'b0);
      txn("wr24_ok", 64'h24, MSIZE4, 8'hFF, 64'h1234, 64'h77, 1'b0);
      txn("rd20_ok", 64'h20, MSIZE8, 8'h00, 64'h0, 64'h1234, 1'b0);
`endif

      repeat (4) @(posedge clk);
      #6;
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
